board_io_conditioner: RTL

Parametrised board-level clock/reset/input conditioning block that sits between FPGA board pins and the `rvsteel` core instance in each board top. It produces a divided core clock with a matching tick, and a debounced, synchronously-released active-high core reset. It also provides CHANNELS synchronised and debounced button/switch inputs with optional edge pulses. It replaces the fixed divide-by-2 and single-flop reset "debounce" used in current board tops.

---
 rtl/board_io_conditioner_pkg.sv | 18 +
 rtl/board_io_conditioner_input_debouncer.sv | 87 ++++++++
 rtl/board_io_conditioner.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/board_io_conditioner_pkg.sv
// board_io_conditioner_pkg
//   Shared types and helpers for the board I/O conditioner.
//   - reset_state_t : reset sequencer states (ACTIVE, HOLD, RUN)
//   - cnt_width()   : bit width of a counter that must hold 0..n-1
package board_io_conditioner_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        HOLD   = 2'd1,
        RUN    = 2'd2
    } reset_state_t;

    // A counter for n states needs at least one bit even when n is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/board_io_conditioner_input_debouncer.sv
// input_debouncer
//   Synchroniser chain followed by a hold-time debouncer for one raw,
//   asynchronous input, with optional accepted-edge pulses.
//   Optional feature macro: BOARD_IO_CONDITIONER_EDGE_EN (builds rise/fall
//   registers; otherwise rise/fall are tied to 0).
// Ports:
//   clock  in  : sampling clock, rising edge
//   reset  in  : asynchronous active-low reset
//   raw    in  : raw pin, asynchronous to clock
//   level  out : debounced level
//   rise   out : one-cycle pulse when an accepted 0->1 lands on level
//   fall   out : one-cycle pulse when an accepted 1->0 lands on level
module input_debouncer
    import board_io_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       db_cnt;
    logic                   stable;
    logic                   sync_val;
    logic                   differs;
    logic                   accept;

    assign sync_val = sync_q[SYNC_STAGES-1];
    assign differs  = (sync_val != stable);
    // The new value has now been seen for DEBOUNCE_CYCLES consecutive cycles.
    assign accept   = differs && (db_cnt == CNT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            db_cnt <= '0;
            stable <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            // Any sample matching the stable value restarts the count, so a
            // glitch shorter than the hold time never gets through.
            if (!differs || accept) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
            if (accept) begin
                stable <= sync_val;
            end
        end
    end

    assign level = stable;

`ifdef BOARD_IO_CONDITIONER_EDGE_EN
    logic rise_q;
    logic fall_q;

    // Registered off the same accept as stable, so the pulse lines up with
    // the level change.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= accept && sync_val;
            fall_q <= accept && !sync_val;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/board_io_conditioner.sv
// board_io_conditioner
//   Board-pin conditioning in front of the core: divided core clock with a
//   matching tick, debounced and synchronously released core reset, and
//   CHANNELS debounced button/switch inputs with optional edge pulses.
//   Optional feature macro: BOARD_IO_CONDITIONER_EDGE_EN (button_rise and
//   button_fall are generated; otherwise they are tied to 0).
// Ports:
//   clock         in  : board oscillator, rising edge
//   reset         in  : asynchronous active-low board reset
//   reset_request in  : raw reset button, active-high, asynchronous
//   button_raw    in  : raw button/switch pins [CHANNELS]
//   clock_div     out : clock / CLOCK_DIVIDER, 50% duty
//   tick          out : pulse in the last clock cycle of each clock_div period
//   reset_out     out : active-high core reset
//   button        out : debounced levels [CHANNELS]
//   button_rise   out : accepted 0->1 pulses [CHANNELS]
//   button_fall   out : accepted 1->0 pulses [CHANNELS]
// The reset sequencer state is the internal signal `state` (reset_state_t).
module board_io_conditioner
    import board_io_conditioner_pkg::*;
#(
    parameter int CLOCK_DIVIDER   = 2,
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RESET_HOLD      = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                reset_request,
    input  logic [CHANNELS-1:0] button_raw,
    output logic                clock_div,
    output logic                tick,
    output logic                reset_out,
    output logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] button_rise,
    output logic [CHANNELS-1:0] button_fall
);

    localparam int                DIV_W     = cnt_width(CLOCK_DIVIDER);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLOCK_DIVIDER - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLOCK_DIVIDER / 2);
    localparam int                HOLD_W    = cnt_width(RESET_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

    // ---------------- clock divider ----------------
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;

    assign div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);

    // Outputs are registered from the next count so they align with div_cnt:
    // clock_div is high for the upper half of the count, tick on the last.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt   <= '0;
            clock_div <= 1'b0;
            tick      <= 1'b0;
        end else begin
            div_cnt   <= div_next;
            clock_div <= (div_next >= DIV_HALF);
            tick      <= (div_next == DIV_LAST);
        end
    end

    // ---------------- input debouncers ----------------
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_button
        input_debouncer #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clock (clock),
            .reset (reset),
            .raw   (button_raw[ch]),
            .level (button[ch]),
            .rise  (button_rise[ch]),
            .fall  (button_fall[ch])
        );
    end

    logic       request_db;
    logic [1:0] request_edge_unused;

    input_debouncer #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_request_debouncer (
        .clock (clock),
        .reset (reset),
        .raw   (reset_request),
        .level (request_db),
        .rise  (request_edge_unused[0]),
        .fall  (request_edge_unused[1])
    );

    // ---------------- reset sequencer ----------------
    reset_state_t      state;
    reset_state_t      state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_next;

    // reset_out is registered from the next state, so it falls on the same
    // edge the sequencer enters RUN and is always released synchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ACTIVE;
            hold_cnt  <= '0;
            reset_out <= 1'b1;
        end else begin
            state     <= state_next;
            hold_cnt  <= hold_next;
            reset_out <= (state_next != RUN);
        end
    end

    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        case (state)
            ACTIVE: begin
                if (!request_db) begin
                    state_next = HOLD;
                    hold_next  = '0;
                end
            end
            HOLD: begin
                // A new request beats the terminal count.
                if (request_db) begin
                    state_next = ACTIVE;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_next = RUN;
                    hold_next  = '0;
                end else begin
                    hold_next = hold_cnt + HOLD_W'(1);
                end
            end
            RUN: begin
                if (request_db) begin
                    state_next = ACTIVE;
                end
            end
            default: begin
                state_next = ACTIVE;
                hold_next  = '0;
            end
        endcase
    end

endmodule
